// File: rtl/pb_debouncer.sv
// Push-button conditioner for one active-low, bouncy, asynchronous key.
// Produces a debounced level plus single-cycle press, release, long-press and
// auto-repeat pulses. Every output is driven straight from a flop.
module pb_debouncer #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_n,
  output logic pb_db_n,
  output logic pb_press,
  output logic pb_release,
  output logic pb_long,
  output logic pb_repeat
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HOLD_W = $clog2(LONG_CYC) + 1;
  localparam int REP_W  = $clog2(REPEAT_CYC) + 1;

  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC - 1);
  // hold_cnt parks here once pb_long has fired, so it never wraps back to 0.
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } state_t;

  logic              sync1_q, sync2_q;
  logic              pressed_s;
  state_t            state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              db_n_d, press_d, release_d, long_d, repeat_d;

  // Two-flop synchroniser; resets to "released" so reset exit never looks like a press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pb_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      pb_db_n    <= 1'b1;
      pb_press   <= 1'b0;
      pb_release <= 1'b0;
      pb_long    <= 1'b0;
      pb_repeat  <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      pb_db_n    <= db_n_d;
      pb_press   <= press_d;
      pb_release <= release_d;
      pb_long    <= long_d;
      pb_repeat  <= repeat_d;
    end
  end

  // Next-state, counter updates and next-cycle output values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    db_n_d     = pb_db_n;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    unique case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d   = ST_PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = ST_RELEASED;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d    = ST_HELD;
          press_d    = 1'b1;
          db_n_d     = 1'b0;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (!pressed_s) begin
          // Counters freeze here; a short release bounce resumes them untouched.
          state_d   = ST_RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_LONG) begin
            long_d    = 1'b1;
            rep_cnt_d = '0;
          end
        end else if (REPEAT_EN != 0) begin
          if (rep_cnt_q == REP_MAX) begin
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end

      ST_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = ST_HELD;
        end else if (deb_cnt_q == DEB_MAX) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
          db_n_d    = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_RELEASED;
    endcase
  end

endmodule

// File: tb/tb_pb_debouncer.sv
// Bench for pb_debouncer with short timing parameters. Two instances share the
// stimulus: one with auto-repeat, one with it disabled. A reference model built
// from the debounce rules (sliding sample window, held-cycle tally) checks both
// every clock; table vectors and hand-written sequences check event timing.
module tb_pb_debouncer;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pb_n = 1'b1;

  logic db_n, press, release_p, long_p, rep_p;
  logic nr_db_n, nr_press, nr_release, nr_long, nr_rep;

  int checks = 0;
  int failures = 0;

  pb_debouncer #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .REPEAT_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_n),
    .pb_db_n(db_n), .pb_press(press), .pb_release(release_p),
    .pb_long(long_p), .pb_repeat(rep_p)
  );

  pb_debouncer #(.DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .REPEAT_EN(0)) dut_norep (
    .clk(clk), .rst_n(rst_n), .pb_n(pb_n),
    .pb_db_n(nr_db_n), .pb_press(nr_press), .pb_release(nr_release),
    .pb_long(nr_long), .pb_repeat(nr_rep)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // s(k) is the pressed sample the debouncer acts on at edge k: the raw key two
  // edges earlier. The level flips once the last D+1 samples all disagree with it.
  // A held cycle is an edge where the level is pressed and both this and the
  // previous sample are pressed; long fires at the L-th held cycle, repeat at
  // every R-th held cycle after that.
  bit m_raw_q[$];
  bit m_win[$];
  bit m_pressed;
  bit m_prev_s;
  int m_held;

  task automatic model_reset();
    m_raw_q = '{1'b1, 1'b1};
    m_win.delete();
    m_pressed = 1'b0;
    m_prev_s = 1'b0;
    m_held = 0;
  endtask

  task automatic model_step();
    bit s, e_press, e_rel, e_long, e_rep, flip;
    int exp_v, exp_nr;
    e_press = 0; e_rel = 0; e_long = 0; e_rep = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      s = ~m_raw_q.pop_front();
      m_raw_q.push_back(pb_n);
      m_win.push_back(s);
      if (m_win.size() > D + 1) void'(m_win.pop_front());
      flip = (m_win.size() == D + 1);
      foreach (m_win[i]) if (m_win[i] == m_pressed) flip = 0;
      if (flip) begin
        m_pressed = ~m_pressed;
        if (m_pressed) e_press = 1; else e_rel = 1;
        m_held = 0;
      end else if (m_pressed && m_prev_s && s) begin
        m_held++;
        if (m_held == L) e_long = 1;
        else if (m_held > L && (m_held - L) % R == 0) e_rep = 1;
      end
      m_prev_s = s;
    end
    exp_v  = {27'd0, ~m_pressed, e_press, e_rel, e_long, e_rep};
    exp_nr = {27'd0, ~m_pressed, e_press, e_rel, e_long, 1'b0};
    check("model_rep",   {27'd0, db_n, press, release_p, long_p, rep_p}, exp_v);
    check("model_norep", {27'd0, nr_db_n, nr_press, nr_release, nr_long, nr_rep}, exp_nr);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      model_step();
    end
  end

  // ---------------- event observation ----------------
  int edge_no;
  int press_at, press_cnt, rel_at, rel_cnt, long_at, long_cnt;
  int rep_first, rep_cnt, nr_long_at, nr_rep_cnt, db_high_after_press, db_low_cnt;

  task automatic clear_obs();
    edge_no = 0;
    press_at = -1; press_cnt = 0; rel_at = -1; rel_cnt = 0;
    long_at = -1; long_cnt = 0; rep_first = -1; rep_cnt = 0;
    nr_long_at = -1; nr_rep_cnt = 0; db_high_after_press = 0; db_low_cnt = 0;
  endtask

  // Drive pb_n for n edges (called at a negedge, returns at a negedge).
  task automatic apply(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      pb_n = lvl;
      @(posedge clk);
      #1;
      edge_no++;
      if (press)     begin if (press_at < 0) press_at = edge_no; press_cnt++; end
      if (release_p) begin if (rel_at < 0) rel_at = edge_no; rel_cnt++; end
      if (long_p)    begin if (long_at < 0) long_at = edge_no; long_cnt++; end
      if (rep_p)     begin if (rep_first < 0) rep_first = edge_no; rep_cnt++; end
      if (nr_long && nr_long_at < 0) nr_long_at = edge_no;
      if (nr_rep) nr_rep_cnt++;
      if (!db_n) db_low_cnt++;
      if (db_n && press_at >= 0 && rel_at < 0) db_high_after_press++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pb_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 3);
    clear_obs();
  endtask

  typedef struct {
    int low_cyc;
    int press_at;
    int rel_at;
    int long_at;
    int rep_cnt;
    int rep_first;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seg;
    logic lvl;

    // pb_n low for low_cyc edges starting at edge 1, then released.
    vecs[0] = '{low_cyc: 3,  press_at: -1, rel_at: -1, long_at: -1, rep_cnt: 0, rep_first: -1};
    vecs[1] = '{low_cyc: 4,  press_at: -1, rel_at: -1, long_at: -1, rep_cnt: 0, rep_first: -1};
    vecs[2] = '{low_cyc: 5,  press_at: 7,  rel_at: 12, long_at: -1, rep_cnt: 0, rep_first: -1};
    vecs[3] = '{low_cyc: 15, press_at: 7,  rel_at: 22, long_at: -1, rep_cnt: 0, rep_first: -1};
    vecs[4] = '{low_cyc: 24, press_at: 7,  rel_at: 31, long_at: -1, rep_cnt: 0, rep_first: -1};
    vecs[5] = '{low_cyc: 25, press_at: 7,  rel_at: 32, long_at: 27, rep_cnt: 0, rep_first: -1};
    vecs[6] = '{low_cyc: 55, press_at: 7,  rel_at: 62, long_at: 27, rep_cnt: 3, rep_first: 35};

    clear_obs();
    do_reset();
    check("reset_db_n", db_n, 1);
    check("reset_pulses", {press, release_p, long_p, rep_p}, 0);

    foreach (vecs[v]) begin
      do_reset();
      apply(1'b0, vecs[v].low_cyc);
      apply(1'b1, 40);
      check($sformatf("v%0d_press_at", v), press_at, vecs[v].press_at);
      check($sformatf("v%0d_press_cnt", v), press_cnt, (vecs[v].press_at < 0) ? 0 : 1);
      check($sformatf("v%0d_rel_at", v), rel_at, vecs[v].rel_at);
      check($sformatf("v%0d_long_at", v), long_at, vecs[v].long_at);
      check($sformatf("v%0d_long_cnt", v), long_cnt, (vecs[v].long_at < 0) ? 0 : 1);
      check($sformatf("v%0d_rep_cnt", v), rep_cnt, vecs[v].rep_cnt);
      check($sformatf("v%0d_rep_first", v), rep_first, vecs[v].rep_first);
      check($sformatf("v%0d_norep_long_at", v), nr_long_at, vecs[v].long_at);
      check($sformatf("v%0d_norep_rep_cnt", v), nr_rep_cnt, 0);
    end

    // Short bounce is rejected, a later clean press is accepted with full latency.
    do_reset();
    apply(1'b0, 3);
    apply(1'b1, 10);
    check("bounce_no_press", press_cnt, 0);
    check("bounce_db_stays_high", db_low_cnt, 0);
    apply(1'b0, 20);
    check("after_bounce_press_at", press_at, 20);
    apply(1'b1, 15);
    check("after_bounce_rel_at", rel_at, 40);

    // Release bounce while held: no release, no second press, hold count frozen.
    do_reset();
    apply(1'b0, 11);
    apply(1'b1, 2);
    apply(1'b0, 27);
    check("holdbounce_press_cnt", press_cnt, 1);
    check("holdbounce_rel_cnt", rel_cnt, 0);
    check("holdbounce_db_low", db_high_after_press, 0);
    check("holdbounce_long_at", long_at, 30);
    check("holdbounce_rep_first", rep_first, 38);

    // Reset while held, then reset exit with the key still down.
    do_reset();
    apply(1'b0, 29);
    check("midreset_long_at", long_at, 27);
    check("midreset_db_before", db_n, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_db_now", db_n, 1);
    check("midreset_norep_db_now", nr_db_n, 1);
    check("midreset_pulses_now", {press, release_p, long_p, rep_p, nr_press, nr_release, nr_long, nr_rep}, 0);
    @(negedge clk);
    @(negedge clk);
    check("midreset_db_held", db_n, 1);
    clear_obs();
    rst_n = 1'b1;
    apply(1'b0, 15);
    check("postreset_press_at", press_at, 7);
    check("postreset_press_cnt", press_cnt, 1);
    check("postreset_no_release", rel_cnt, 0);

    // Random bouncy key with occasional resets; the model checks every edge.
    seg = 0;
    lvl = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lvl = ~lvl;
        seg = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 7);
      end
      seg--;
      pb_n = lvl;
      rst_n = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
